// File: rtl/c_frag_cfg.sv
// Serial configuration loader for the logic-cell mux fragment inverter selects.
// Shifts in 8 data bits MSB first plus a parity bit, checks parity, then commits to inv.
module c_frag_cfg #(
    parameter logic [7:0] INIT       = 8'h00,
    parameter logic       PARITY_ODD = 1'b1
) (
    input  logic       qck,
    input  logic       qrt_n,
    input  logic       cfg_start,
    input  logic       cfg_din,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_lock,
    output logic [7:0] inv,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic       busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   inv_d;
    logic                err_d, done_d, ready_d, busy_d;
    logic                parity_ok;

    assign parity_ok = ((^shadow_q) ^ par_q) == PARITY_ODD;

    // State register; ready/busy are registered from the next-state decode.
    always_ff @(posedge qck or negedge qrt_n) begin
        if (!qrt_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            par_q     <= 1'b0;
            inv       <= INIT;
            cfg_err   <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            par_q     <= par_d;
            inv       <= inv_d;
            cfg_err   <= err_d;
            cfg_done  <= done_d;
            cfg_ready <= ready_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        par_d    = par_q;
        inv_d    = inv;
        err_d    = cfg_err;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    shadow_d = '0;
                    err_d    = 1'b0;
                end
            end
            SHIFT: begin
                // A restart discards any transfer offered in the same cycle.
                if (cfg_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                    err_d    = 1'b0;
                end else if (cfg_valid && cfg_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q < CNT_W'(DATA_W)) begin
                        shadow_d = {shadow_q[DATA_W-2:0], cfg_din};
                    end else begin
                        par_d   = cfg_din;
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!parity_ok) begin
                    err_d = 1'b1;
                end else if (!cfg_lock) begin
                    inv_d   = shadow_q;
                    state_d = COMMIT;
                    done_d  = 1'b1;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == SHIFT);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: doc/c_frag_cfg.md
C_FRAG_CFG -- requirements
Module: c_frag_cfg

Interface
REQ-001 Parameter INIT, default 8'h00, reset value of INV.
REQ-002 Parameter PARITY_ODD, default 1'b1; 1 = odd parity over data+parity bit, 0 = even.
REQ-003 QCK  input  1  clock; all state changes on rising edge.
REQ-004 QRT_N  input  1  reset, asynchronous, active-low.
REQ-005 CFG_START  input  1  begin (or restart) a configuration frame.
REQ-006 CFG_DIN  input  1  serial config bit.
REQ-007 CFG_VALID  input  1  CFG_DIN valid this cycle.
REQ-008 CFG_READY  output  1  block accepts a bit this cycle.
REQ-009 CFG_LOCK  input  1  inhibit commit of a received frame.
REQ-010 INV  output  8  inverter selects feeding the logic cell mux fragment: bit7..0 = TAS1,TAS2,TBS1,TBS2,BAS1,BAS2,BBS1,BBS2.
REQ-011 CFG_DONE  output  1  one-cycle pulse when INV takes a new frame.
REQ-012 CFG_ERR  output  1  sticky parity-error flag.
REQ-013 BUSY  output  1  high whenever state is not IDLE.

Function
REQ-014 States IDLE, SHIFT, CHECK, COMMIT; encoding free; no other reachable state.
REQ-015 Transfer = CFG_VALID & CFG_READY at a rising edge; CFG_READY SHALL be 1 only in SHIFT.
REQ-016 IDLE: CFG_START=1 -> SHIFT; bit count <= 0, shadow <= 0, CFG_ERR <= 0.
REQ-017 SHIFT, transfers 1..8: shadow <= {shadow[6:0], CFG_DIN} (MSB first).
REQ-018 SHIFT, transfer 9: parity bit latched, state -> CHECK; count SHALL never exceed 9.
REQ-019 SHIFT with CFG_VALID=0: all state held, no timeout.
REQ-020 CFG_START=1 in SHIFT: restart (count 0, shadow 0, ERR 0); restart wins over a simultaneous transfer, which is discarded.
REQ-021 CFG_START in CHECK or COMMIT ignored.
REQ-022 CHECK (exactly one cycle): parity_ok = (XOR of shadow XOR parity bit) == PARITY_ODD.
REQ-023 CHECK, parity_ok & !CFG_LOCK: at that edge INV <= shadow, state -> COMMIT.
REQ-024 CHECK, !parity_ok: CFG_ERR <= 1, INV unchanged, -> IDLE (error wins regardless of CFG_LOCK).
REQ-025 CHECK, parity_ok & CFG_LOCK: frame discarded, INV unchanged, CFG_ERR unchanged, no DONE, -> IDLE.
REQ-026 COMMIT (one cycle): CFG_DONE=1 (registered), -> IDLE unconditionally.
REQ-027 Latency: 9th transfer at edge N; INV updates at edge N+1; CFG_DONE high between edges N+1 and N+2.
REQ-028 INV SHALL change only on REQ-023 or reset; glitch-free (direct register output).
REQ-029 CFG_ERR stays 1 until next accepted CFG_START or reset.

Reset
REQ-030 QRT_N=0 SHALL immediately force: state IDLE, count 0, shadow 0, INV=INIT, CFG_READY 0, CFG_DONE 0, CFG_ERR 0, BUSY 0.
REQ-031 Reset mid-frame aborts the frame; no partial frame reaches INV.
REQ-032 Reset release SHALL be synchronous-safe: first transition no earlier than the first rising QCK after QRT_N rises.

Verification
REQ-033 Reset, START, bits 0,0,1,1,1,1,0,0 then parity 1, VALID continuous -> INV=8'h3C one edge after 9th transfer, CFG_DONE one cycle, CFG_ERR 0.
REQ-034 Same frame with parity 0 -> CFG_ERR=1, INV stays 8'h00, no CFG_DONE, BUSY 0 after CHECK.
REQ-035 Frame 8'h81 parity 1 with CFG_VALID toggling every other cycle -> INV=8'h81; only VALID&READY cycles counted.
REQ-036 Frame 8'hFF parity 1 with CFG_LOCK=1 during CHECK -> INV unchanged, CFG_DONE 0, CFG_ERR 0.
REQ-037 CFG_START re-asserted after 4 bits (same cycle as VALID) -> restart; following full frame 8'h81 parity 1 commits 8'h81.
REQ-038 INV=8'h3C, then QRT_N low mid-frame (async, between edges) -> INV=INIT, CFG_READY 0, BUSY 0 before next edge.
